// File: rtl/sw_debounce_pkg.sv
// Shared types for the switch debouncer: per-channel FSM state, event codes, event record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } db_state_e;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;

    typedef struct packed {
        logic [2:0] ch;
        logic [1:0] code;
    } evt_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, IDLE/DB_PRESS/HELD/DB_RELEASE FSM, hold timer.
// Latency: level and event pulse update 2+DEBOUNCE cycles after a clean input edge.
// Backpressure: none; o_evt_vld is a one-cycle pulse, buffering is the parent's job.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_sw raw level;
//        o_level debounced level; o_evt_vld/o_evt_code one-cycle event pulse.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE   = 2600000,
    parameter int LONG_PRESS = 52000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sw,
    output logic       o_level,
    output logic       o_evt_vld,
    output logic [1:0] o_evt_code
);

    localparam int            CW       = $clog2(LONG_PRESS + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(LONG_PRESS);

    logic          sync1_q;
    logic          sync2_q;
    db_state_e     state_q;
    logic [CW-1:0] db_cnt_q;
    logic [CW-1:0] hold_q;
    logic          level_q;
    logic          evt_vld_q;
    logic [1:0]    evt_code_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_q     <= '0;
            level_q    <= 1'b0;
            evt_vld_q  <= 1'b0;
            evt_code_q <= EVT_PRESS;
        end else begin
            sync1_q   <= i_sw;
            sync2_q   <= sync1_q;
            evt_vld_q <= 1'b0;

            // Hold timer runs through DB_RELEASE too, so a bounce that falls back
            // to HELD does not restart the long-press measurement. It saturates
            // at LONG_PRESS, which makes the LONG event one-shot per press.
            if ((state_q == ST_HELD || state_q == ST_DB_RELEASE) && hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 1'b1;
                if (hold_q == HOLD_MAX - 1'b1) begin
                    evt_vld_q  <= 1'b1;
                    evt_code_q <= EVT_LONG;
                end
            end

            // A release commit below overrides a coincident LONG code.
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q) begin
                        state_q  <= ST_DB_PRESS;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!sync2_q) begin
                        state_q <= ST_IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_HELD;
                        level_q    <= 1'b1;
                        hold_q     <= '0;
                        evt_vld_q  <= 1'b1;
                        evt_code_q <= EVT_PRESS;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q) begin
                        state_q  <= ST_DB_RELEASE;
                        db_cnt_q <= '0;
                    end
                end
                ST_DB_RELEASE: begin
                    if (sync2_q) begin
                        state_q <= ST_HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= ST_IDLE;
                        level_q    <= 1'b0;
                        evt_vld_q  <= 1'b1;
                        evt_code_q <= EVT_RELEASE;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_level    = level_q;
    assign o_evt_vld  = evt_vld_q;
    assign o_evt_code = evt_code_q;

endmodule

// File: rtl/sw_debounce.sv
// N_CH switch debouncer with press/release/long-press events through a pending stage and FIFO.
// Latency: event visible on o_evt_valid 2 cycles after its commit edge (pending -> FIFO).
// Backpressure: valid/ready on the event head; full FIFO holds events pending, a full pending slot drops and sets o_ovf.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_sw raw levels; o_level debounced levels;
//        o_evt_valid/o_evt_ch/o_evt_code/i_evt_ready event stream; o_ovf sticky drop flag.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEBOUNCE   = 2600000,
    parameter int LONG_PRESS = 52000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_sw,
    output logic [N_CH-1:0] o_level,
    output logic            o_evt_valid,
    output logic [2:0]      o_evt_ch,
    output logic [1:0]      o_evt_code,
    input  logic            i_evt_ready,
    output logic            o_ovf
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [N_CH-1:0] ch_evt_vld;
    logic [1:0]      ch_evt_code [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE   (DEBOUNCE),
            .LONG_PRESS (LONG_PRESS)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_sw       (i_sw[k]),
            .o_level    (o_level[k]),
            .o_evt_vld  (ch_evt_vld[k]),
            .o_evt_code (ch_evt_code[k])
        );
    end

    logic [N_CH-1:0] pend_vld_q, pend_vld_d;
    logic [1:0]      pend_code_q [N_CH];
    logic [1:0]      pend_code_d [N_CH];
    logic            ovf_q, ovf_d;
    evt_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;

    logic            arb_found;
    evt_t            push_evt;
    logic            push, pop, fifo_full;

    always_comb begin
        // Fixed priority: lowest channel index with a pending event wins.
        arb_found = 1'b0;
        push_evt  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (pend_vld_q[k] && !arb_found) begin
                arb_found     = 1'b1;
                push_evt.ch   = 3'(k);
                push_evt.code = pend_code_q[k];
            end
        end

        fifo_full = (cnt_q == FULL_CNT);
        pop       = o_evt_valid && i_evt_ready;
        // A pop frees the slot this same cycle, so a full FIFO still accepts.
        push      = arb_found && (!fifo_full || pop);

        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        ovf_d       = ovf_q;
        for (int k = 0; k < N_CH; k++) begin
            if (push && push_evt.ch == 3'(k)) begin
                pend_vld_d[k] = 1'b0;
            end
            if (ch_evt_vld[k]) begin
                if (pend_vld_d[k]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_vld_d[k]  = 1'b1;
                    pend_code_d[k] = ch_evt_code[k];
                end
            end
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_vld_q <= '0;
            for (int k = 0; k < N_CH; k++) pend_code_q[k] <= EVT_PRESS;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_evt;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign o_evt_valid = (cnt_q != '0);
    assign o_evt_ch    = mem_q[rd_ptr_q].ch;
    assign o_evt_code  = mem_q[rd_ptr_q].code;
    assign o_ovf       = ovf_q;

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of switch/button input channels (1..8).
REQ-002 The block SHALL have parameter DEBOUNCE, default 2600000, giving the consecutive stable cycles required to accept a level change (>=2).
REQ-003 The block SHALL have parameter LONG_PRESS, default 52000000, giving the cycles held after an accepted press before a long-press event is emitted (>DEBOUNCE).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, giving the event queue depth (power of 2).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_sw, input, N_CH bits: raw asynchronous switch/button levels, 1 = pressed.
REQ-008 The block SHALL have port o_level, output, N_CH bits: the debounced stable level per channel.
REQ-009 The block SHALL have port o_evt_valid, output, 1 bit: the event queue head is valid.
REQ-010 The block SHALL have port o_evt_ch, output, 3 bits: the channel index of the head event.
REQ-011 The block SHALL have port o_evt_code, output, 2 bits: the head event code (0 PRESS, 1 RELEASE, 2 LONG; 3 is never emitted).
REQ-012 The block SHALL have port i_evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-013 The block SHALL have port o_ovf, output, 1 bit: sticky flag set when an event was dropped.

Function
REQ-014 Each i_sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each channel SHALL run an FSM with states IDLE (level 0), DB_PRESS, HELD (level 1) and DB_RELEASE.
REQ-016 IDLE SHALL go to DB_PRESS when the synced input is 1, clearing the counter.
REQ-017 In DB_PRESS, synced input 0 SHALL return to IDLE, and DEBOUNCE consecutive 1s SHALL go to HELD, set o_level, and raise a PRESS event.
REQ-018 HELD/DB_RELEASE SHALL behave symmetrically, returning to IDLE, clearing o_level, and raising a RELEASE event.
REQ-019 o_level[k] SHALL change exactly 2+DEBOUNCE cycles after a clean input edge; a glitch shorter than DEBOUNCE cycles SHALL produce no change and no event.
REQ-020 In HELD, a hold counter SHALL count from entry; at LONG_PRESS cycles it SHALL raise exactly one LONG event per press, and the counter SHALL saturate.
REQ-021 Time spent in DB_RELEASE that aborts back to HELD SHALL NOT reset the hold counter.
REQ-022 Counters SHALL be sized $clog2(LONG_PRESS+1) bits and SHALL never wrap.
REQ-023 Each channel SHALL hold one pending-event register.
REQ-024 A new event on a channel whose pending register is still full SHALL be dropped and SHALL set o_ovf.
REQ-025 The arbiter SHALL move at most one pending event per cycle into the FIFO, lowest channel index first.
REQ-026 A pending event SHALL NOT move into a full FIFO; it SHALL stay pending.
REQ-027 o_evt_valid SHALL be 1 whenever the FIFO is non-empty; the head SHALL be popped on valid & ready.
REQ-028 o_evt_ch and o_evt_code SHALL be stable while valid & !ready.
REQ-029 A simultaneous pop and push on a full FIFO SHALL both occur.
REQ-030 Minimum latency from the commit edge to o_evt_valid SHALL be 2 cycles (pending -> FIFO -> visible).

Reset
REQ-031 Asserting i_rst_n low SHALL clear synchronizers, FSMs (IDLE), counters, pending registers, FIFO pointers, o_level, o_evt_valid, o_evt_ch, o_evt_code and o_ovf to 0.
REQ-032 Reset asserted mid-debounce or mid-hold SHALL discard all state; a button held through reset release SHALL produce a fresh PRESS after 2+DEBOUNCE cycles.
REQ-033 o_ovf SHALL clear only on reset.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the event code constants (EVT_PRESS/EVT_RELEASE/EVT_LONG) and the event struct {ch, code}.
REQ-035 Per-channel synchronizer, FSM and counters SHALL be the sub-module sw_debounce_ch, instantiated N_CH times.
REQ-036 The arbiter and FIFO SHALL be in the top module.

Verification (DEBOUNCE=4, LONG_PRESS=20, FIFO_DEPTH=4)
REQ-037 i_sw[0] 0->1 held, ready=1 -> o_level[0]=1 six cycles after the edge; PRESS ch0 valid for one cycle two cycles later.
REQ-038 A 3-cycle pulse on i_sw[1] -> no o_level change, no event.
REQ-039 i_sw[2] held 40 cycles then released -> events in order PRESS ch2, LONG ch2 (20 cycles after PRESS commit), RELEASE ch2; exactly one LONG.
REQ-040 Channels 0..3 pressed in the same cycle, ready=0 -> four events queued in ch0..ch3 order, valid held, o_ovf=0; release all and wait -> RELEASE events stay pending, o_ovf=0; one further event on a pending channel -> o_ovf=1.
REQ-041 ready toggled 1/0 every cycle during the REQ-040 drain -> each event delivered exactly once and unchanged while stalled.
REQ-042 i_rst_n pulsed low mid-DB_PRESS on ch3 with button held -> all outputs 0 immediately; PRESS ch3 reappears 2+DEBOUNCE cycles after reset release.
